// File: rtl/fifo_demux_salida.sv
// Per-lane 4-deep circular buffer behind one demux output; 1-cycle registered pop latency.
// Overflowing pushes are dropped and latch a sticky error; flags decode the registered count.
module fifo_demux_salida #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Entrada,
  input  logic                  validEntrada,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] Salida,
  output logic                  validSalida,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // A pop on a non-empty buffer frees a slot in the same cycle, so full+pop still accepts a push.
  assign do_pop  = pop && (count != '0);
  assign do_push = validEntrada && ((count != DEPTH_C) || do_pop);

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= Entrada;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      Salida      <= '0;
      validSalida <= 1'b0;
      error       <= 1'b0;
    end else begin
      validSalida <= do_pop;
      if (do_pop) begin
        Salida <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (validEntrada && !do_push) begin
        error <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fifo_demux_salida.md
# fifo_demux_salida

Per-lane output buffer placed directly downstream of the first-level 1-to-2 demux layer. It captures each valid 8-bit word the demux emits on one output lane, holds it in a circular FIFO, and releases words to the next stage on a pop request. It also reports occupancy flags so upstream flow control can throttle the demux. One instance is placed per demux output lane: four instances for the four-lane L1 layer.

## Interface
Parameters:
- DATA_WIDTH, 8, word width (matches demux lanes)
- ADDR_WIDTH, 2, pointer width; depth = 2**ADDR_WIDTH (4 words)
- ALMOST_FULL, 3, `almost_full` asserts when count >= this value
- ALMOST_EMPTY, 1, `almost_empty` asserts when count <= this value

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- Entrada  in  DATA_WIDTH  word from demux lane (`Salida0`/`Salida1` of the demux)
- validEntrada  in  1  push request; word on `Entrada` is written when high
- pop  in  1  read request from downstream
- Salida  out  DATA_WIDTH  registered read data
- validSalida  out  1  high for one cycle when `Salida` carries a popped word
- full  out  1  count == depth
- empty  out  1  count == 0
- almost_full  out  1  count >= ALMOST_FULL
- almost_empty  out  1  count <= ALMOST_EMPTY
- error  out  1  sticky overflow indicator

## Operation
- State:
  - write pointer `wr_ptr` (ADDR_WIDTH bits)
  - read pointer `rd_ptr` (ADDR_WIDTH bits)
  - `count` (ADDR_WIDTH+1 bits, range 0..depth)
  - storage array of depth × DATA_WIDTH
  - `Salida`, `validSalida` and `error` registers
- Push accepted when `validEntrada` is high and (`count` < depth, or `pop` is high with `count` > 0).
  - Accepted push writes `mem[wr_ptr]` and increments `wr_ptr`, wrapping modulo depth.
- Push while full without a qualifying pop:
  - The word is dropped.
  - Memory and pointers are unchanged.
  - `error` is set to 1 and stays 1 until reset.
- Pop accepted when `pop` is high and `count` > 0.
  - `Salida` loads `mem[rd_ptr]` and `validSalida` is 1 on the next cycle.
  - `rd_ptr` increments, wrapping modulo depth.
- Pop when empty:
  - No-op. `validSalida` is 0 and `Salida` holds its last value.
  - `error` is not affected.
- Simultaneous push and pop:
  - When `count` > 0, both are performed and `count` is unchanged.
  - When `count` == 0, only the push is performed. There is no fall-through; the word becomes poppable the following cycle.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Flags are combinational decodes of the registered `count`, so they reflect the state after the most recent edge.
- Outputs when `reset` is low, applied asynchronously:
  - pointers, `count`, `Salida` = 0
  - `validSalida` = 0, `error` = 0
  - `empty` = 1, `almost_empty` = 1
  - `full` = 0, `almost_full` = 0
  - Memory contents need not be cleared.
- Reset asserted mid-operation discards all buffered words. The first push after reset release is written to address 0.

## Timing
- Push to `empty` deassert: 1 cycle (the flag updates at the same edge that writes the word).
- Push to earliest pop: the pop may be issued in the cycle after the push edge.
- Pop to data: `Salida`/`validSalida` are valid 1 cycle after the pop edge, i.e. registered read latency of 1.
- Sustained throughput: 1 push and 1 pop per cycle once non-empty.
- `error` rises at the clock edge that drops the overflowing word.
- Reset release is synchronous to use: the first edge with `reset` high is the first functional edge.

## Test plan
- Reset check: hold `reset` low with random inputs → `Salida` = 0, `validSalida` = 0, `empty` = 1, `almost_empty` = 1, `full` = 0, `error` = 0.
- Fill and drain with default parameters:
  - Push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles → `almost_full` at count 3, `full` at count 4.
  - Then pop 4 times → `Salida` is 0xA1, 0xB2, 0xC3, 0xD4, each with `validSalida` = 1 one cycle after its pop; `empty` = 1 at the end.
- Overflow:
  - From full, push 0xEE with `pop` = 0 → word dropped, `error` = 1 and held.
  - Subsequent pops return only the original 4 words.
- Full with simultaneous push/pop:
  - With `full` = 1, push 0x55 and pop in the same cycle → `Salida` = oldest word, `count` stays 4, `error` stays 0.
  - 0x55 emerges after 3 further pops.
- Pointer wrap: stream 10 words 0x00..0x09 with push and pop concurrent from cycle 2 → output order is preserved across the wrap of both pointers.
- Empty corner cases:
  - Pop on empty → `validSalida` = 0.
  - Simultaneous push 0x77 and pop on empty → no output that cycle; `empty` = 0; next pop yields 0x77.
  - Assert `reset` mid-stream → all flags return to reset values immediately.
